cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface. Latches N/Z/V/C from flag-setting EX-stage ops (ADDS/SUBS/ANDS) into an architectural flags register.
- Tracks in-flight flag writers and evaluates branch conditions (B.cond, CBZ, CBNZ, B) for the branch unit.
- Returns a registered taken/not-taken response through a valid/ready handshake.
- Sits beside the EX stage and feeds PC-select logic.

Parameters:
- FWD_EN, 1, 1 = bypass incoming EX flags to a same-cycle condition request; 0 = stall instead.
- PEND_W, 2, width of the in-flight flag-writer counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fs_issue  in  1  a flag-setting op enters ID/EX this cycle.
- flag_we  in  1  a flag-setting op is in EX this cycle; commit alu flags.
- alu_neg  in  1  ALU Negative.
- alu_zero  in  1  ALU Zero.
- alu_ovf  in  1  ALU Overflow.
- alu_cout  in  1  ALU CarryOut.
- flush  in  1  kill younger in-flight ops and any outstanding response.
- cond_valid  in  1  branch evaluation request.
- cond_ready  out  1  request accepted this cycle when valid & ready.
- cond_kind  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional).
- cond_code  in  4  LEGv8 condition field (EQ=0000 ... AL=1110, NV=1111).
- op_zero  in  1  Zero of the compared register (ALU pass-B result), used by CBZ/CBNZ.
- resp_valid  out  1  one-cycle pulse: branch decision available.
- resp_taken  out  1  branch decision.
- flags_nzvc  out  4  architectural flags {N,Z,V,C}.
- pend_err  out  1  sticky: counter overflow or underflow.

Behaviour:
- Reset (async assert, sync release):
  - flags_nzvc=0000, counter=0, resp_valid=0, resp_taken=0, pend_err=0.
  - cond_ready follows its combinational rule: 1 after reset.
- Flags register: on a clock edge with flag_we=1, flags_nzvc <= {alu_neg, alu_zero, alu_ovf, alu_cout}; otherwise hold. flush does not block flag_we, because the op in EX is older than the flush.
- Pending counter, evaluated per edge:
  - flush=1: counter <= 0 (a same-cycle fs_issue is discarded).
  - fs_issue and flag_we both 1: counter unchanged.
  - fs_issue only: increment. If already at 2^PEND_W-1, saturate and set pend_err.
  - flag_we only: decrement. If already 0, hold at 0 and set pend_err.
- Effective flags F:
  - Use {alu_*} when FWD_EN=1 and flag_we=1.
  - Otherwise use flags_nzvc.
- cond_ready is combinational:
  - 0 when flush=1.
  - 1 when cond_kind is 01, 10 or 11 (no flag dependence).
  - For B.cond: 1 if counter==0, or if FWD_EN=1 and counter==1 and flag_we=1. Otherwise 0.
- Condition table, evaluated on F:
  - EQ Z; NE !Z
  - HS C; LO !C
  - MI N; PL !N
  - VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL and NV: always taken.
- Decision by kind: CBZ taken = op_zero; CBNZ taken = !op_zero; B taken = 1.
- Latency: a request accepted at edge k gives resp_valid=1 and resp_taken after edge k, held for exactly one cycle. Back-to-back requests are accepted every cycle, giving one response per cycle.
- Flush: on an edge with flush=1, resp_valid <= 0 and resp_taken <= 0; no request is accepted that cycle.
- Hold: when cond_valid=0 or cond_ready=0, resp_valid <= 0 and resp_taken holds its last value.
- Reset mid-operation: all state clears immediately. Any outstanding response is lost.

Test Plan:
- Reset release, cond_valid=1, kind=00, code=EQ, no writers pending → cond_ready=1; next cycle resp_valid=1, resp_taken=0 (flags 0000).
- flag_we with alu N=0,Z=1,V=0,C=1 (SUBS 5-5), then B.EQ and B.HS → flags_nzvc=0101; both responses taken=1; B.LO taken=0.
- fs_issue at cycle 0, B.GT request at cycle 1 with flag_we=1 and alu N=1,V=1,Z=0:
  - FWD_EN=1: accepted in cycle 1, taken=1.
  - FWD_EN=0: cond_ready=0 in cycle 1, accepted in cycle 2, taken=1.
- Two fs_issue pulses with no flag_we, then B.NE → cond_ready stays 0 until both flag_we pulses occur. CBZ with op_zero=1 during the stall is accepted immediately, taken=1.
- Counter at 3 (PEND_W=2) plus a further fs_issue → counter stays 3, pend_err=1. flush → counter=0, pend_err stays 1. flag_we with counter 0 → pend_err remains 1.
- Accepted request at edge k, flush asserted in the following cycle → resp_valid=1 for the cycle after edge k, then 0. Drop reset_n mid-cycle → flags_nzvc=0000 and resp_valid=0 immediately.

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZVC flags, in-flight flag-writer tracking and
// branch-condition evaluation with a registered valid/ready response.
module cond_flag_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fs_issue,
    input  logic       flag_we,
    input  logic       alu_neg,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    input  logic       alu_cout,
    input  logic       flush,
    input  logic       cond_valid,
    output logic       cond_ready,
    input  logic [1:0] cond_kind,
    input  logic [3:0] cond_code,
    input  logic       op_zero,
    output logic       resp_valid,
    output logic       resp_taken,
    output logic [3:0] flags_nzvc,
    output logic       pend_err
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [3:0]        flags_q, eff_f, alu_f;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d, valid_q, taken_q;
    logic              inc, dec, accept, cc_taken, taken_d;
    logic [7:0]        base_v;

    assign alu_f = {alu_neg, alu_zero, alu_ovf, alu_cout};
    assign eff_f = (FWD_EN && flag_we) ? alu_f : flags_q;
    assign inc   = !flush && fs_issue && !flag_we;
    assign dec   = !flush && flag_we && !fs_issue;

    always_comb begin
        pend_d = flush ? '0 : inc ? (pend_q == PEND_MAX ? pend_q : pend_q + 1'b1) :
                 dec ? (pend_q == '0 ? pend_q : pend_q - 1'b1) : pend_q;
        err_d  = err_q || (inc && pend_q == PEND_MAX) || (dec && pend_q == '0);
    end

    // Even codes test the base predicate, odd codes its inverse; 111x is always taken.
    always_comb begin
        base_v     = {1'b1,
                      !eff_f[2] && (eff_f[3] == eff_f[1]),
                      eff_f[3] == eff_f[1],
                      eff_f[0] && !eff_f[2],
                      eff_f[1], eff_f[3], eff_f[0], eff_f[2]};
        cc_taken   = (cond_code[3:1] == 3'b111) ? 1'b1 : base_v[cond_code[3:1]] ^ cond_code[0];
        taken_d    = (cond_kind == 2'b00) ? cc_taken :
                     (cond_kind == 2'b01) ? op_zero :
                     (cond_kind == 2'b10) ? !op_zero : 1'b1;
        cond_ready = flush ? 1'b0 :
                     (cond_kind != 2'b00) ? 1'b1 :
                     (pend_q == '0) || (FWD_EN && pend_q == PEND_W'(1) && flag_we);
        accept     = cond_valid && cond_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            flags_q <= flag_we ? alu_f : flags_q;
            pend_q  <= pend_d;
            err_q   <= err_d;
            valid_q <= accept;
            taken_q <= flush ? 1'b0 : accept ? taken_d : taken_q;
        end
    end

    assign flags_nzvc = flags_q;
    assign pend_err   = err_q;
    assign resp_valid = valid_q;
    assign resp_taken = taken_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed plus random checks of both forwarding variants
// against an arithmetic reference model of the flag/branch rules.
module tb_cond_flag_unit;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       fs_issue, flag_we, alu_neg, alu_zero, alu_ovf, alu_cout, flush;
    logic       cond_valid, op_zero;
    logic [1:0] cond_kind;
    logic [3:0] cond_code;
    logic       rdy [2];
    logic       rv [2];
    logic       rt [2];
    logic [3:0] fl [2];
    logic       pe [2];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int       m_pend [2];
    bit [3:0] m_flags [2];
    bit       m_v [2];
    bit       m_t [2];
    bit       m_err [2];

    always #5 clk = ~clk;

    cond_flag_unit #(.FWD_EN(1'b0), .PEND_W(2)) d0 (
        .clk(clk), .reset_n(reset_n), .fs_issue(fs_issue), .flag_we(flag_we),
        .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
        .flush(flush), .cond_valid(cond_valid), .cond_ready(rdy[0]), .cond_kind(cond_kind),
        .cond_code(cond_code), .op_zero(op_zero), .resp_valid(rv[0]), .resp_taken(rt[0]),
        .flags_nzvc(fl[0]), .pend_err(pe[0]));

    cond_flag_unit #(.FWD_EN(1'b1), .PEND_W(2)) d1 (
        .clk(clk), .reset_n(reset_n), .fs_issue(fs_issue), .flag_we(flag_we),
        .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
        .flush(flush), .cond_valid(cond_valid), .cond_ready(rdy[1]), .cond_kind(cond_kind),
        .cond_code(cond_code), .op_zero(op_zero), .resp_valid(rv[1]), .resp_taken(rt[1]),
        .flags_nzvc(fl[1]), .pend_err(pe[1]));

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_eval(bit [3:0] f, bit [3:0] code);
        bit n = f[3], z = f[2], v = f[1], c = f[0];
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_ready(int fwd);
        if (flush) return 1'b0;
        if (cond_kind != 2'd0) return 1'b1;
        return m_pend[fwd] == 0 || (fwd == 1 && m_pend[fwd] == 1 && flag_we);
    endfunction

    function automatic bit m_decide(int fwd);
        bit [3:0] f = (fwd == 1 && flag_we) ? {alu_neg, alu_zero, alu_ovf, alu_cout} : m_flags[fwd];
        case (cond_kind)
            2'd0: return cond_eval(f, cond_code);
            2'd1: return op_zero;
            2'd2: return !op_zero;
            default: return 1'b1;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_flags[i] = 4'h0; m_v[i] = 0; m_t[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic drive(bit fs, bit fw, bit [3:0] nzvc, bit fl_, bit cv, bit [1:0] kind,
                         bit [3:0] code, bit oz);
        fs_issue = fs; flag_we = fw; {alu_neg, alu_zero, alu_ovf, alu_cout} = nzvc;
        flush = fl_; cond_valid = cv; cond_kind = kind; cond_code = code; op_zero = oz;
    endtask

    // Called just after a rising edge with the next cycle's inputs applied.
    task automatic tick();
        int       np [2];
        bit [3:0] nf [2];
        bit       nv [2], nt [2], ne [2];
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), {3'b0, rdy[i]}, {3'b0, m_ready(i)});
            chk($sformatf("resp_valid%0d", i), {3'b0, rv[i]}, {3'b0, m_v[i]});
            chk($sformatf("resp_taken%0d", i), {3'b0, rt[i]}, {3'b0, m_t[i]});
            chk($sformatf("flags%0d", i), fl[i], m_flags[i]);
            chk($sformatf("pend_err%0d", i), {3'b0, pe[i]}, {3'b0, m_err[i]});
            np[i] = m_pend[i]; ne[i] = m_err[i];
            if (flush) np[i] = 0;
            else if (fs_issue && !flag_we) begin
                if (m_pend[i] == 3) ne[i] = 1; else np[i] = m_pend[i] + 1;
            end else if (flag_we && !fs_issue) begin
                if (m_pend[i] == 0) ne[i] = 1; else np[i] = m_pend[i] - 1;
            end
            nf[i] = flag_we ? {alu_neg, alu_zero, alu_ovf, alu_cout} : m_flags[i];
            nv[i] = !flush && cond_valid && m_ready(i);
            nt[i] = flush ? 1'b0 : nv[i] ? m_decide(i) : m_t[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = np[i]; m_flags[i] = nf[i]; m_v[i] = nv[i]; m_t[i] = nt[i]; m_err[i] = ne[i];
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", fl[1], 4'h0);
        chk("reset_valid", {3'b0, rv[0]}, 4'h0);
        reset_n = 1'b1;
        // B.EQ straight out of reset with flags 0000
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd0, 0);
        tick();
        chk("rst_beq_valid", {3'b0, rv[1]}, 4'h1);
        chk("rst_beq_taken", {3'b0, rt[1]}, 4'h0);
        // SUBS 5-5 writes NZVC=0101
        drive(1, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0); tick();
        drive(0, 1, 4'h5, 0, 0, 2'd0, 4'd0, 0); tick();
        chk("subs_flags", fl[0], 4'h5);
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd0, 0); tick();
        chk("beq_taken", {3'b0, rt[0]}, 4'h1);
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd2, 0); tick();
        chk("bhs_taken", {3'b0, rt[0]}, 4'h1);
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd3, 0); tick();
        chk("blo_taken", {3'b0, rt[1]}, 4'h0);
        // B.GT racing its flag writer: bypass vs stall
        drive(1, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0); tick();
        drive(0, 1, 4'hA, 0, 1, 2'd0, 4'd12, 0); tick();
        chk("fwd_gt_valid", {3'b0, rv[1]}, 4'h1);
        chk("fwd_gt_taken", {3'b0, rt[1]}, 4'h1);
        chk("stall_gt_valid", {3'b0, rv[0]}, 4'h0);
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd12, 0); tick();
        chk("stall_gt_late", {3'b0, rv[0]}, 4'h1);
        chk("stall_gt_taken", {3'b0, rt[0]}, 4'h1);
        // two writers in flight, B.NE stalls, CBZ passes
        drive(1, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0); tick();
        drive(1, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0); tick();
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd1, 0); tick();
        chk("bne_stalled", {3'b0, rv[1]}, 4'h0);
        drive(0, 0, 4'h0, 0, 1, 2'd1, 4'd1, 1); tick();
        chk("cbz_taken", {3'b0, rt[1]}, 4'h1);
        drive(0, 1, 4'h0, 0, 1, 2'd0, 4'd1, 0); tick();
        drive(0, 1, 4'h0, 0, 1, 2'd0, 4'd1, 0); tick();
        drive(0, 0, 4'h0, 0, 1, 2'd0, 4'd1, 0); tick();
        chk("bne_after", {3'b0, rv[0]}, 4'h1);
        // saturate counter, then flush and underflow
        drive(1, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0);
        repeat (4) tick();
        chk("sat_err", {3'b0, pe[1]}, 4'h1);
        drive(0, 0, 4'h0, 1, 0, 2'd0, 4'd0, 0); tick();
        drive(0, 1, 4'h3, 0, 0, 2'd0, 4'd0, 0); tick();
        chk("err_sticky", {3'b0, pe[0]}, 4'h1);
        // response followed by flush, then async reset mid-cycle
        drive(0, 0, 4'h0, 0, 1, 2'd3, 4'd0, 0); tick();
        chk("b_valid", {3'b0, rv[1]}, 4'h1);
        drive(0, 0, 4'h0, 1, 1, 2'd3, 4'd0, 0); tick();
        chk("flush_valid", {3'b0, rv[1]}, 4'h0);
        drive(0, 1, 4'hF, 0, 1, 2'd3, 4'd0, 0); tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_flags", fl[1], 4'h0);
        chk("async_valid", {3'b0, rv[1]}, 4'h0);
        m_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, 0, 4'h0, 0, 0, 2'd0, 4'd0, 0);
        tick();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 2'($urandom),
                  4'($urandom), 1'($urandom));
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
